// File: rtl/alu_core.sv
// RV32I execute-stage ALU: combinational result on alu_data plus a registered
// copy on alu_data_r for the downstream pipeline register.
module alu_core (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic [3:0]  alu_op,
  output logic [31:0] alu_data,
  output logic [31:0] alu_data_r
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_SLT  = 4'h2,
    OP_SLTU = 4'h3,
    OP_XOR  = 4'h4,
    OP_OR   = 4'h5,
    OP_AND  = 4'h6,
    OP_SLL  = 4'h7,
    OP_SRL  = 4'h8,
    OP_SRA  = 4'h9
  } alu_op_e;

  logic [4:0]  shamt;
  logic [31:0] alu_data_d;
  logic [31:0] alu_data_q;

  // Only the low five bits of operand_b form the shift distance.
  assign shamt = operand_b[4:0];

  always_comb begin
    alu_data_d = 32'h0;
    case (alu_op)
      OP_ADD:  alu_data_d = operand_a + operand_b;
      OP_SUB:  alu_data_d = operand_a - operand_b;
      OP_SLT:  alu_data_d = {31'h0, $signed(operand_a) < $signed(operand_b)};
      OP_SLTU: alu_data_d = {31'h0, operand_a < operand_b};
      OP_XOR:  alu_data_d = operand_a ^ operand_b;
      OP_OR:   alu_data_d = operand_a | operand_b;
      OP_AND:  alu_data_d = operand_a & operand_b;
      OP_SLL:  alu_data_d = operand_a << shamt;
      OP_SRL:  alu_data_d = operand_a >> shamt;
      OP_SRA:  alu_data_d = $unsigned($signed(operand_a) >>> shamt);
      default: alu_data_d = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_data_q <= 32'h0;
    end else begin
      alu_data_q <= alu_data_d;
    end
  end

  assign alu_data   = alu_data_d;
  assign alu_data_r = alu_data_q;

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed vectors, randomized checks against
// an arithmetic reference model, and the registered/reset path.
module tb_alu_core;

  logic        clk;
  logic        rst;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_data;
  logic [31:0] alu_data_r;

  int tests_run;
  int tests_failed;

  alu_core alu (
    .clk        (clk),
    .rst        (rst),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .alu_op     (alu_op),
    .alu_data   (alu_data),
    .alu_data_r (alu_data_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model from the arithmetic definition of each operation.
  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    longint m;
    longint ua;
    longint ub;
    longint sa;
    longint sb;
    longint p;
    longint q;
    longint r;
    m  = 64'h1_0000_0000;
    ua = longint'(a);
    ub = longint'(b);
    sa = (a >= 32'h8000_0000) ? ua - m : ua;
    sb = (b >= 32'h8000_0000) ? ub - m : ub;
    p  = 1;
    for (int i = 0; i < int'(b % 32); i++) p = p * 2;
    r = 0;
    case (op)
      4'h0: r = (ua + ub) % m;
      4'h1: r = (ua - ub + m) % m;
      4'h2: r = (sa < sb) ? 1 : 0;
      4'h3: r = (ua < ub) ? 1 : 0;
      4'h4: r = longint'(a ^ b);
      4'h5: r = longint'(a | b);
      4'h6: r = longint'(a & b);
      4'h7: r = (ua * p) % m;
      4'h8: r = ua / p;
      4'h9: begin
        q = sa / p;
        if (sa < 0 && (sa % p) != 0) q = q - 1;
        r = (q + m) % m;
      end
      default: r = 0;
    endcase
    return r[31:0];
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    operand_a = 32'h1234_5678;
    operand_b = 32'h0123_4567;
    alu_op = 4'h0;
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (alu_data_r !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_async: alu_data_r=%h expected=%h", alu_data_r, 32'h0);
    end
    @(posedge clk); #1;
    tests_run++;
    if (alu_data_r !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_hold: alu_data_r=%h expected=%h", alu_data_r, 32'h0);
    end
    tests_run++;
    if (alu_data !== 32'h1357_9BDF) begin
      tests_failed++;
      $display("FAIL reset_comb: alu_data=%h expected=%h", alu_data, 32'h1357_9BDF);
    end
    $display("[TB] reset: alu_data_r=%h alu_data=%h", alu_data_r, alu_data);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] exp;
  } vec_t;

  task automatic test_directed();
    vec_t v[$];
    v.push_back('{32'h1234_5678, 32'h0123_4567, 4'h0, 32'h1357_9BDF});
    v.push_back('{32'h0123_4567, 32'h1234_5678, 4'h0, 32'h1357_9BDF});
    v.push_back('{32'h0123_4567, 32'h89AB_CDEF, 4'h0, 32'h8ACF_1356});
    v.push_back('{32'h0123_4567, 32'h89AB_CDEF, 4'h1, 32'h7777_7778});
    v.push_back('{32'h0123_4567, 32'h89AB_CDEF, 4'h2, 32'h0});
    v.push_back('{32'h0123_4567, 32'h89AB_CDEF, 4'h3, 32'h1});
    v.push_back('{32'h89AB_CDEF, 32'h0123_4567, 4'h2, 32'h1});
    v.push_back('{32'h89AB_CDEF, 32'h0123_4567, 4'h3, 32'h0});
    v.push_back('{32'h0123_4567, 32'h0123_4567, 4'h2, 32'h0});
    v.push_back('{32'h0123_4567, 32'h0123_4567, 4'h3, 32'h0});
    v.push_back('{32'h89AB_CDEF, 32'h8765_4321, 4'h2, 32'h0});
    v.push_back('{32'h89AB_CDEF, 32'h8765_4321, 4'h3, 32'h0});
    v.push_back('{32'h8765_4321, 32'h89AB_CDEF, 4'h2, 32'h1});
    v.push_back('{32'h8765_4321, 32'h89AB_CDEF, 4'h3, 32'h1});
    v.push_back('{32'h8765_4321, 32'h89AB_CDEF, 4'h4, 32'h0ECE_8ECE});
    v.push_back('{32'h1234_5678, 32'h0123_4567, 4'h4, 32'h1317_131F});
    v.push_back('{32'h1234_5678, 32'h0123_4567, 4'h5, 32'h1337_577F});
    v.push_back('{32'h1234_5678, 32'h0123_4567, 4'h6, 32'h0020_4460});
    v.push_back('{32'h1234_5678, 32'h0123_4567, 4'h7, 32'h1A2B_3C00});
    v.push_back('{32'h0123_4567, 32'h1234_5678, 4'h7, 32'h6700_0000});
    v.push_back('{32'h89AB_CDEF, 32'h0123_4567, 4'h7, 32'hD5E6_F780});
    v.push_back('{32'h89AB_CDEF, 32'h0123_4567, 4'h8, 32'h0113_579B});
    v.push_back('{32'h89AB_CDEF, 32'h89AB_CDEF, 4'h8, 32'h0001_1357});
    v.push_back('{32'h89AB_CDEF, 32'h89AB_CDEF, 4'h9, 32'hFFFF_1357});
    v.push_back('{32'h0123_4567, 32'h89AB_CDEF, 4'h9, 32'h0000_0246});
    v.push_back('{32'h89AB_CDEF, 32'hFFFF_FFE0, 4'h9, 32'h89AB_CDEF});
    v.push_back('{32'h89AB_CDEF, 32'hFFFF_FFE0, 4'h8, 32'h89AB_CDEF});
    v.push_back('{32'h1234_5678, 32'h0123_4567, 4'hB, 32'h0});
    foreach (v[i]) begin
      operand_a = v[i].a;
      operand_b = v[i].b;
      alu_op    = v[i].op;
      #1;
      tests_run++;
      if (alu_data !== v[i].exp) begin
        tests_failed++;
        $display("FAIL directed_%0d: op=%h a=%h b=%h alu_data=%h expected=%h",
                 i, v[i].op, v[i].a, v[i].b, alu_data, v[i].exp);
      end else begin
        $display("[TB] directed_%0d: op=%h a=%h b=%h alu_data=%h", i, v[i].op, v[i].a, v[i].b,
                 alu_data);
      end
    end
  endtask

  task automatic test_reserved();
    for (int op = 10; op < 16; op++) begin
      operand_a = $urandom | 32'h1;
      operand_b = $urandom | 32'h1;
      alu_op    = 4'(op);
      #1;
      tests_run++;
      if (alu_data !== 32'h0) begin
        tests_failed++;
        $display("FAIL reserved_%h: alu_data=%h expected=%h", alu_op, alu_data, 32'h0);
      end else begin
        $display("[TB] reserved op=%h alu_data=%h", alu_op, alu_data);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] exp;
    for (int i = 0; i < 400; i++) begin
      operand_a = pick_operand();
      operand_b = ($urandom_range(0, 9) == 0) ? operand_a : pick_operand();
      alu_op    = 4'($urandom_range(0, 15));
      exp = ref_alu(operand_a, operand_b, alu_op);
      #1;
      tests_run++;
      if (alu_data !== exp) begin
        tests_failed++;
        $display("FAIL random_%0d: op=%h a=%h b=%h alu_data=%h expected=%h",
                 i, alu_op, operand_a, operand_b, alu_data, exp);
      end else begin
        $display("[TB] random_%0d: op=%h a=%h b=%h alu_data=%h", i, alu_op, operand_a,
                 operand_b, alu_data);
      end
    end
  endtask

  task automatic test_register();
    @(posedge clk); #1;
    operand_a = 32'h1234_5678;
    operand_b = 32'h0123_4567;
    alu_op    = 4'h0;
    @(posedge clk); #1;
    tests_run++;
    if (alu_data_r !== 32'h1357_9BDF) begin
      tests_failed++;
      $display("FAIL register_capture: alu_data_r=%h expected=%h", alu_data_r, 32'h1357_9BDF);
    end else begin
      $display("[TB] register_capture: alu_data_r=%h", alu_data_r);
    end
    // Mid-cycle reset clears the register but leaves the combinational path alone.
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (alu_data_r !== 32'h0) begin
      tests_failed++;
      $display("FAIL register_midreset: alu_data_r=%h expected=%h", alu_data_r, 32'h0);
    end
    tests_run++;
    if (alu_data !== 32'h1357_9BDF) begin
      tests_failed++;
      $display("FAIL midreset_comb: alu_data=%h expected=%h", alu_data, 32'h1357_9BDF);
    end
    $display("[TB] mid_reset: alu_data_r=%h alu_data=%h", alu_data_r, alu_data);
    @(posedge clk); #3;
    rst = 1'b0;
    operand_a = 32'h0123_4567;
    operand_b = 32'h89AB_CDEF;
    alu_op    = 4'h1;
    #1;
    tests_run++;
    if (alu_data_r !== 32'h0) begin
      tests_failed++;
      $display("FAIL register_postreset_hold: alu_data_r=%h expected=%h", alu_data_r, 32'h0);
    end
    @(posedge clk); #1;
    tests_run++;
    if (alu_data_r !== 32'h7777_7778) begin
      tests_failed++;
      $display("FAIL register_first_capture: alu_data_r=%h expected=%h", alu_data_r,
               32'h7777_7778);
    end else begin
      $display("[TB] first_capture: alu_data_r=%h", alu_data_r);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] prev_exp;
    @(posedge clk); #1;
    operand_a = pick_operand();
    operand_b = pick_operand();
    alu_op    = 4'($urandom_range(0, 15));
    prev_exp  = ref_alu(operand_a, operand_b, alu_op);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (alu_data_r !== prev_exp) begin
        tests_failed++;
        $display("FAIL b2b_%0d: alu_data_r=%h expected=%h", i, alu_data_r, prev_exp);
      end else begin
        $display("[TB] b2b_%0d: alu_data_r=%h", i, alu_data_r);
      end
      operand_a = pick_operand();
      operand_b = pick_operand();
      alu_op    = 4'($urandom_range(0, 15));
      prev_exp  = ref_alu(operand_a, operand_b, alu_op);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_directed();
    test_reserved();
    test_random();
    test_register();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
